// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side arbiter.
// Holds the arbiter state encoding and the default sizing parameters.
package fifo_pkg;

    localparam int unsigned N_REQ_DEF     = 4;
    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned MAX_BURST_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotating-priority picker: returns the first asserted request at or above
// rr_ptr, wrapping past N_REQ-1 back to 0. Purely combinational.
// Ports:
//   req    [N_REQ-1:0]  request vector
//   rr_ptr [PTR_W-1:0]  index holding highest priority
//   valid               any request asserted
//   idx    [PTR_W-1:0]  chosen requester (0 when none)
module fifo_rr_pick
    import fifo_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    // Walk the candidates in priority order; modulo by subtraction so
    // non-power-of-two N_REQ wraps correctly.
    always_comb begin
        int unsigned c;
        logic        found;
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            c = 32'(rr_ptr) + k;
            if (c >= N_REQ) begin
                c = c - N_REQ;
            end
            if (!found && req[PTR_W'(c)]) begin
                idx   = PTR_W'(c);
                found = 1'b1;
            end
        end
        valid = found;
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Write-side arbiter: grants one of N_REQ requesters ownership of the FIFO
// write port for a burst of up to MAX_BURST words, round-robin between
// grants, and stalls cleanly on w_full.
// Ports:
//   w_clk, w_rst         write clock, async active-low reset
//   req, req_last        per-requester word valid / end-of-packet
//   req_data             packed per-requester data slices
//   w_full               FIFO full flag
//   gnt, owner           registered one-hot owner and its index
//   ack, w_inc, w_data   combinational accept pulse, write strobe, data
module fifo_wr_arb
    import fifo_pkg::*;
#(
    parameter int unsigned N_REQ     = N_REQ_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic                      w_clk,
    input  logic                      w_rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          req_last,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic                      w_full,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          ack,
    output logic                      w_inc,
    output logic [DATA_W-1:0]         w_data,
    output logic [$clog2(N_REQ)-1:0]  owner
);

    localparam int unsigned PTR_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

    state_t             state_q,  state_d;
    logic [N_REQ-1:0]   gnt_q,    gnt_d;
    logic [PTR_W-1:0]   owner_q,  owner_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;

    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic               in_burst;
    logic               own_req;
    logic               last_word;

    fifo_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    // Write path: only the owner's request and data are ever observed.
    assign in_burst  = (state_q == BURST);
    assign own_req   = req[owner_q];
    assign last_word = req_last[owner_q] | (cnt_q == CNT_W'(MAX_BURST - 1));
    assign w_inc     = in_burst & own_req & ~w_full;
    assign ack       = gnt_q & {N_REQ{w_inc}};
    assign w_data    = in_burst ? req_data[32'(owner_q) * DATA_W +: DATA_W] : '0;

    assign gnt   = gnt_q;
    assign owner = owner_q;

    // State and ownership registers.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic. A stalled word (w_full) never advances or releases;
    // a dropped owner request releases without writing.
    always_comb begin
        logic rel;
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        rel      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BURST;
                    gnt_d   = N_REQ'(1) << pick_idx;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (!own_req) begin
                    rel = 1'b1;
                end else if (w_inc) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    rel   = last_word;
                end
            end
        endcase

        if (rel) begin
            state_d  = IDLE;
            gnt_d    = '0;
            owner_d  = '0;
            rr_ptr_d = (32'(owner_q) == N_REQ - 1) ? '0 : owner_q + PTR_W'(1);
        end
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, the number of write requesters (range 2..8).
REQ-002 The block SHALL have parameter DATA_W, default 8, the data word width.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, the maximum number of words written per grant (range 1..16).
REQ-004 The block SHALL have port w_clk, input, 1 bit: the write-domain clock; all state changes on its rising edge.
REQ-005 The block SHALL have port w_rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, N_REQ bits: per-requester write request; req[i] high means requester i has a word on its data slice.
REQ-007 The block SHALL have port req_last, input, N_REQ bits: marks the current word of requester i as the final word of its packet.
REQ-008 The block SHALL have port req_data, input, N_REQ*DATA_W bits: slice i is bits [i*DATA_W +: DATA_W].
REQ-009 The block SHALL have port w_full, input, 1 bit: the FIFO write-side full flag.
REQ-010 The block SHALL have port gnt, output, N_REQ bits: one-hot current owner; all zero when idle.
REQ-011 The block SHALL have port ack, output, N_REQ bits: one-hot pulse when the owner's word is accepted this cycle.
REQ-012 The block SHALL have port w_inc, output, 1 bit: the FIFO write strobe.
REQ-013 The block SHALL have port w_data, output, DATA_W bits: the FIFO write data.
REQ-014 The block SHALL have port owner, output, $clog2(N_REQ) bits: the index of the current owner; 0 when idle.

Function
REQ-015 The state machine SHALL have exactly two states, IDLE and BURST.
REQ-016 In IDLE with any req bit high, the block SHALL select the first asserted requester searching upward from rr_ptr with wrap-around, register gnt and owner, and enter BURST on the next edge.
REQ-017 Request-to-grant latency SHALL be 1 cycle; the first write MAY occur in the first BURST cycle.
REQ-018 In BURST, w_inc SHALL equal req[owner] AND NOT w_full, combinationally.
REQ-019 ack SHALL equal gnt AND w_inc.
REQ-020 w_data SHALL equal req_data slice [owner] while in BURST, and 0 in IDLE.
REQ-021 The burst counter (width $clog2(MAX_BURST)+1) SHALL clear on grant and increment only on w_inc.
REQ-022 When w_full is high, the block SHALL hold the grant with no write and no count advance, with no timeout.
REQ-023 The grant SHALL be released (next state IDLE, gnt cleared) on a w_inc cycle in which req_last[owner] is high or the counter equals MAX_BURST-1.
REQ-024 The grant SHALL also be released when req[owner] is low while in BURST; no write occurs in that cycle.
REQ-025 On release, rr_ptr SHALL become (owner+1) mod N_REQ, computed without relying on power-of-two N_REQ.
REQ-026 Every grant SHALL be followed by at least one IDLE cycle before the next grant.
REQ-027 Changes of req or req_data on non-owner requesters SHALL have no effect during BURST.
REQ-028 When simultaneous requests arrive, the block SHALL apply round-robin only; with all N_REQ requesting continuously, each requester SHALL be granted once per N_REQ grants.
REQ-029 When w_full and release conditions coincide, w_full SHALL take precedence; no release occurs on a stalled word.

Reset
REQ-030 While w_rst is low, the block SHALL force state=IDLE, gnt=0, ack=0, w_inc=0, w_data=0, owner=0, rr_ptr=0 and counter=0, asynchronously.
REQ-031 On reset mid-burst, the block SHALL drop w_inc immediately, and SHALL grant requester 0 first after deassertion if it requests.
REQ-032 The first grant SHALL be possible on the first rising edge after w_rst deasserts.

Structure
REQ-033 The state encoding and the default values of N_REQ, DATA_W and MAX_BURST SHALL live in the shared package fifo_pkg.
REQ-034 The rotating-priority search SHALL be a combinational sub-module fifo_rr_pick (inputs req and rr_ptr; outputs valid and idx).
REQ-035 The top-level block SHALL instantiate fifo_rr_pick once and SHALL contain no other sub-modules.

Verification
REQ-036 Bench scenario, single requester: req=4'b0010 with 3 words, last on word 3 -> gnt=4'b0010 one cycle later; 3 consecutive w_inc carrying data slice 1; then IDLE.
REQ-037 Bench scenario, round-robin: req=4'b1111 held with req_last always high -> grant order 0,1,2,3,0; one IDLE cycle between grants.
REQ-038 Bench scenario, burst cap: MAX_BURST=4, requester 2 streams 10 words, no last -> 4 writes, release, re-grant to requester 2 (sole requester), 4 writes, and so on.
REQ-039 Bench scenario, backpressure: w_full high for 5 cycles mid-burst -> w_inc=0 and ack=0 throughout, counter frozen, grant held, no lost or duplicated word.
REQ-040 Bench scenario, requester drop: owner 3 lowers req after 1 word -> release with no write; next grant goes to requester 0 if requesting.
REQ-041 Bench scenario, reset mid-burst: w_rst low during BURST -> all outputs 0 immediately; after deassertion with req=4'b0100, requester 2 is granted.
